// File: rtl/instr_loader_if.sv
// Instruction-memory write bus between the SPI loader and the instruction RAM.
// The loader is the master; the memory (or a bench monitor) is the slave.
interface instr_loader_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/instr_loader.sv
// SPI mode-0 boot loader: receives a framed program image, writes it word by word
// into instruction memory and holds the core in reset until a start command.
module instr_loader #(
  parameter logic [31:0] IMEM_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  instr_loader_if.master        imem,
  output logic                  load_done,
  output logic                  op_err,
  output logic                  cpu_rst_n
);

  typedef enum logic [2:0] {IDLE, CMD, CNT_HI, CNT_LO, DATA, DRAIN} state_t;

  localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);
  localparam logic [7:0]  CMD_LOAD  = 8'hA5;
  localparam logic [7:0]  CMD_START = 8'h5A;

  state_t      state_q, state_d;
  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_q, cs_q;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  tx_sr, echo;
  logic [7:0]  cnt_hi;
  logic [15:0] word_total, rx_words, widx;
  logic [1:0]  byte_in_word;
  logic [23:0] word_sr;
  logic        done_pend;

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic        byte_done, last_word;
  logic [7:0]  rx_byte;
  logic [15:0] count_full;

  function automatic logic opcode_ok(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: opcode_ok = 1'b1;
      default:                                         opcode_ok = 1'b0;
    endcase
  endfunction

  // NOTE: cs_n synchroniser resets to "selected" so a frame already in progress
  // when rst releases can never produce a falling edge; only a rise re-arms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  assign sclk_rise  = sclk_sync[1] & ~sclk_q;
  assign sclk_fall  = ~sclk_sync[1] & sclk_q;
  assign cs_fall    = ~cs_sync[1] & cs_q;
  assign cs_rise    = cs_sync[1] & ~cs_q;
  assign mosi_s     = mosi_sync[1];
  assign rx_byte    = {rx_sr, mosi_s};
  assign byte_done  = sclk_rise && (bit_cnt == 3'd7) && (state_q != IDLE);
  assign count_full = {cnt_hi, rx_byte};
  assign last_word  = (byte_in_word == 2'd3) && ((rx_words + 16'd1) == word_total);
  assign spi_miso   = tx_sr[7] && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d takes its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall)   state_d = CMD;
        CMD:     if (byte_done) state_d = (rx_byte == CMD_LOAD) ? CNT_HI : DRAIN;
        CNT_HI:  if (byte_done) state_d = CNT_LO;
        CNT_LO:  if (byte_done) state_d = (count_full == 16'd0) ? DRAIN : DATA;
        DATA:    if (byte_done && last_word) state_d = DRAIN;
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem.we      <= 1'b0;
      imem.addr    <= IMEM_BASE;
      imem.wdata   <= 32'h0;
      load_done    <= 1'b0;
      op_err       <= 1'b0;
      cpu_rst_n    <= 1'b0;
      bit_cnt      <= 3'd0;
      rx_sr        <= 7'h0;
      tx_sr        <= 8'h0;
      echo         <= 8'h0;
      cnt_hi       <= 8'h0;
      word_total   <= 16'd0;
      rx_words     <= 16'd0;
      widx         <= 16'd0;
      byte_in_word <= 2'd0;
      word_sr      <= 24'h0;
      done_pend    <= 1'b0;
    end else begin
      imem.we <= 1'b0;
      if (done_pend) begin
        load_done <= 1'b1;
        done_pend <= 1'b0;
      end
      if (cs_rise) begin
        // An aborted frame drops any partial byte, count or word.
        bit_cnt      <= 3'd0;
        byte_in_word <= 2'd0;
      end else begin
        if (state_q == IDLE && cs_fall) begin
          bit_cnt      <= 3'd0;
          byte_in_word <= 2'd0;
          tx_sr        <= {cpu_rst_n, load_done, op_err, 5'b0};
        end
        if (state_q != IDLE) begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= {rx_sr[5:0], mosi_s};
          end
          // The fall just after a byte boundary presents the echo byte's MSB.
          if (sclk_fall) tx_sr <= (bit_cnt == 3'd0) ? echo : {tx_sr[6:0], 1'b0};
        end
        if (byte_done) begin
          echo <= rx_byte;
          case (state_q)
            CMD: begin
              if (rx_byte == CMD_LOAD) begin
                load_done <= 1'b0;
                op_err    <= 1'b0;
                cpu_rst_n <= 1'b0;
                widx      <= 16'd0;
                rx_words  <= 16'd0;
                done_pend <= 1'b0;
              end else if (rx_byte == CMD_START) begin
                if (load_done) cpu_rst_n <= 1'b1;
                else           op_err    <= 1'b1;
              end
            end
            CNT_HI: cnt_hi <= rx_byte;
            CNT_LO: begin
              word_total   <= count_full;
              byte_in_word <= 2'd0;
              if (count_full == 16'd0)          load_done <= 1'b1;
              if ({1'b0, count_full} > MAX_W)   op_err    <= 1'b1;
            end
            DATA: begin
              byte_in_word <= byte_in_word + 2'd1;
              if (byte_in_word == 2'd3) begin
                rx_words <= rx_words + 16'd1;
                if ({1'b0, widx} < MAX_W) begin
                  imem.we    <= 1'b1;
                  imem.addr  <= IMEM_BASE + {14'b0, widx, 2'b00};
                  imem.wdata <= {word_sr, rx_byte};
                  widx       <= widx + 16'd1;
                  if (!opcode_ok(rx_byte[6:0])) op_err <= 1'b1;
                end
                if (last_word) done_pend <= 1'b1;
              end else begin
                word_sr <= {word_sr[15:0], rx_byte};
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: default instance plus a MAX_WORDS=2 instance
// sharing one SPI host; memory writes are captured by negedge monitors.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic miso0, miso1;
  logic done0, done1, err0, err1, crst0, crst1;

  int errors = 0;
  int checks = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

  instr_loader_if imem0 ();
  instr_loader_if imem1 ();

  instr_loader dut0 (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(miso0), .imem(imem0.master), .load_done(done0), .op_err(err0), .cpu_rst_n(crst0)
  );

  instr_loader #(.MAX_WORDS(2)) dut1 (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(miso1), .imem(imem1.master), .load_done(done1), .op_err(err1), .cpu_rst_n(crst1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem0.we) begin wa0.push_back(imem0.addr); wd0.push_back(imem0.wdata); end
    if (imem1.we) begin wa1.push_back(imem1.addr); wd1.push_back(imem1.wdata); end
  end

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    q_at = (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      #80;
      spi_sclk = 1'b1;
      r[i] = miso0;
      #80;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic xfer_word(input logic [31:0] w);
    logic [7:0] r;
    for (int i = 3; i >= 0; i--) xfer(w[8*i +: 8], r);
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    #160;
  endtask

  task automatic frame_end();
    #80;
    spi_cs_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem0.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", imem0.we); end
    checks++; if (imem0.addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem0.addr); end
    checks++; if (imem0.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", imem0.wdata); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err0); end
    checks++; if (crst0 !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n: got %b want 0", crst0); end
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso0); end
    rst = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_load();
    logic [7:0] r0, r1, r2, r3;
    clear_mon();
    frame_begin();
    xfer(8'hA5, r0); xfer(8'h00, r1); xfer(8'h02, r2);
    xfer(8'h00, r3); xfer(8'h00, r3); xfer(8'h02, r3); xfer(8'h93, r3);
    xfer_word(32'h0010_0313);
    frame_end();
    checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL load_status: got %h want 00", r0); end
    checks++; if (r1 !== 8'hA5) begin errors++; $display("FAIL load_echo1: got %h want a5", r1); end
    checks++; if (r2 !== 8'h00) begin errors++; $display("FAIL load_echo2: got %h want 00", r2); end
    checks++; if (r3 !== 8'h02) begin errors++; $display("FAIL load_echo4: got %h want 02", r3); end
    checks++; if (wa0.size() !== 2) begin errors++; $display("FAIL load_nwrites: got %0d want 2", wa0.size()); end
    checks++; if (q_at(wa0, 0) !== 32'h0) begin errors++; $display("FAIL load_addr0: got %h want 0", q_at(wa0, 0)); end
    checks++; if (q_at(wd0, 0) !== 32'h0000_0293) begin errors++; $display("FAIL load_data0: got %h want 00000293", q_at(wd0, 0)); end
    checks++; if (q_at(wa0, 1) !== 32'h4) begin errors++; $display("FAIL load_addr1: got %h want 4", q_at(wa0, 1)); end
    checks++; if (q_at(wd0, 1) !== 32'h0010_0313) begin errors++; $display("FAIL load_data1: got %h want 00100313", q_at(wd0, 1)); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL load_done: got %b want 1", done0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", err0); end
    checks++; if (crst0 !== 1'b0) begin errors++; $display("FAIL load_cpu_rst_n: got %b want 0", crst0); end
  endtask

  task automatic test_start();
    logic [7:0] r;
    frame_begin();
    xfer(8'h5A, r);
    frame_end();
    checks++; if (r !== 8'h40) begin errors++; $display("FAIL start_status: got %h want 40", r); end
    checks++; if (crst0 !== 1'b1) begin errors++; $display("FAIL start_cpu_rst_n: got %b want 1", crst0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL start_err: got %b want 0", err0); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] r, rd;
    clear_mon();
    frame_begin();
    xfer(8'hA5, r); xfer(8'h00, rd); xfer(8'h01, rd);
    xfer_word(32'hFFFF_FFFF);
    frame_end();
    checks++; if (r !== 8'hC0) begin errors++; $display("FAIL badop_status: got %h want c0", r); end
    checks++; if (wa0.size() !== 1) begin errors++; $display("FAIL badop_nwrites: got %0d want 1", wa0.size()); end
    checks++; if (q_at(wa0, 0) !== 32'h0) begin errors++; $display("FAIL badop_addr: got %h want 0", q_at(wa0, 0)); end
    checks++; if (q_at(wd0, 0) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL badop_data: got %h want ffffffff", q_at(wd0, 0)); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL badop_err: got %b want 1", err0); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL badop_done: got %b want 1", done0); end
    checks++; if (crst0 !== 1'b0) begin errors++; $display("FAIL badop_cpu_rst_n: got %b want 0", crst0); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    clear_mon();
    frame_begin();
    xfer(8'hA5, r); xfer(8'h00, r); xfer(8'h03, r);
    xfer_word(32'h0000_0293);
    xfer(8'h00, r); xfer(8'h10, r);
    frame_end();
    checks++; if (wa0.size() !== 1) begin errors++; $display("FAIL abort_nwrites: got %0d want 1", wa0.size()); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done0); end
    checks++; if (crst0 !== 1'b0) begin errors++; $display("FAIL abort_cpu_rst_n: got %b want 0", crst0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL abort_err_cleared: got %b want 0", err0); end
    frame_begin();
    xfer(8'h5A, r);
    frame_end();
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL abort_start_err: got %b want 1", err0); end
    checks++; if (crst0 !== 1'b0) begin errors++; $display("FAIL abort_start_cpu_rst_n: got %b want 0", crst0); end
  endtask

  task automatic test_zero_count();
    logic [7:0] r;
    clear_mon();
    frame_begin();
    xfer(8'hA5, r); xfer(8'h00, r); xfer(8'h00, r);
    frame_end();
    checks++; if (wa0.size() !== 0) begin errors++; $display("FAIL zero_nwrites: got %0d want 0", wa0.size()); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", err0); end
  endtask

  task automatic test_max_words();
    logic [7:0] r;
    clear_mon();
    frame_begin();
    xfer(8'hA5, r); xfer(8'h00, r); xfer(8'h03, r);
    xfer_word(32'h0000_0293);
    xfer_word(32'h0010_0313);
    xfer_word(32'h0000_0013);
    frame_end();
    checks++; if (wa1.size() !== 2) begin errors++; $display("FAIL max_nwrites: got %0d want 2", wa1.size()); end
    checks++; if (q_at(wd1, 1) !== 32'h0010_0313) begin errors++; $display("FAIL max_data1: got %h want 00100313", q_at(wd1, 1)); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL max_err: got %b want 1", err1); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", done1); end
    checks++; if (wa0.size() !== 3) begin errors++; $display("FAIL max_default_nwrites: got %0d want 3", wa0.size()); end
    checks++; if (q_at(wa0, 2) !== 32'h8) begin errors++; $display("FAIL max_default_addr2: got %h want 8", q_at(wa0, 2)); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL max_default_err: got %b want 0", err0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic [7:0] ror;
    clear_mon();
    frame_begin();
    xfer(8'hA5, r); xfer(8'h00, r); xfer(8'h03, r);
    xfer_word(32'hFFFF_FFFF);
    xfer_word(32'h0000_0293);
    xfer(8'h00, r);
    #40;
    rst = 1'b0;
    #1;
    checks++; if (imem0.addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", imem0.addr); end
    checks++; if (imem0.wdata !== 32'h0) begin errors++; $display("FAIL rstmid_wdata: got %h want 0", imem0.wdata); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b want 0", err0); end
    checks++; if (imem0.we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b want 0", imem0.we); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done0); end
    checks++; if (crst0 !== 1'b0) begin errors++; $display("FAIL rstmid_cpu_rst_n: got %b want 0", crst0); end
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b want 0", miso0); end
    #39;
    rst = 1'b1;
    clear_mon();
    ror = 8'h00;
    xfer(8'h00, r); ror = ror | r;
    xfer(8'h00, r); ror = ror | r;
    xfer(8'h13, r); ror = ror | r;
    xfer(8'hA5, r); ror = ror | r;
    xfer_word(32'h0000_0293);
    frame_end();
    checks++; if (wa0.size() !== 0) begin errors++; $display("FAIL rstmid_ignored_writes: got %0d want 0", wa0.size()); end
    checks++; if (ror !== 8'h00) begin errors++; $display("FAIL rstmid_ignored_miso: got %h want 00", ror); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rstmid_ignored_done: got %b want 0", done0); end
    frame_begin();
    xfer(8'hA5, r); xfer(8'h00, r); xfer(8'h01, r);
    xfer_word(32'h0010_0313);
    frame_end();
    checks++; if (wa0.size() !== 1) begin errors++; $display("FAIL rstmid_reload_nwrites: got %0d want 1", wa0.size()); end
    checks++; if (q_at(wd0, 0) !== 32'h0010_0313) begin errors++; $display("FAIL rstmid_reload_data: got %h want 00100313", q_at(wd0, 0)); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL rstmid_reload_done: got %b want 1", done0); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_start();
    test_bad_opcode();
    test_abort();
    test_zero_count();
    test_max_words();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
